// File: rtl/sap_pkg.sv
// Shared SAP-1.5 definitions: data-path width and the button debounce state encoding.
package sap_pkg;

    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } debounce_state_t;

endpackage

// File: rtl/input_port_debounce.sv
// Button synchroniser and debouncer: emits the debounced level and a one-cycle capture
// pulse on each accepted press. Reusable for any future panel button.
module debounce
    import sap_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic capture
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      btn_sync;
    logic            btn_s;
    debounce_state_t state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    assign btn_s = btn_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync <= '0;
            state    <= IDLE;
            cnt      <= '0;
        end else begin
            btn_sync <= {btn_sync[0], btn};
            state    <= state_next;
            cnt      <= cnt_next;
        end
    end

    // The counter saturates rather than wrapping so a stuck level can never alias a fresh count.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    capture    = 1'b1;
                    state_next = HELD;
                end else if (cnt != '1) begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_next = HELD;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                end else if (cnt != '1) begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign level = (state == HELD) || (state == RELEASE_WAIT);

endmodule

// File: rtl/input_port.sv
// SAP-1.5 operator input: switch synchroniser, debounced enter button, holding register
// with ready/read handshake. Define INPUT_PORT_OVERRUN_EN to get a sticky overrun flag.
module input_port #(
    parameter int DATA_WIDTH      = sap_pkg::DATA_WIDTH,
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] sw_i,
    input  logic                  btn_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  ready_o,
    output logic                  overrun_o,
    output logic                  btn_level_o
);

    import sap_pkg::*;

    logic [DATA_WIDTH-1:0] sw_meta;
    logic [DATA_WIDTH-1:0] sw_sync;
    logic                  capture;
    logic                  load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw_i;
            sw_sync <= sw_meta;
        end
    end

    debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (btn_i),
        .level   (btn_level_o),
        .capture (capture)
    );

    // A read in the capture cycle frees the register first, so the new byte still lands.
    assign load = capture && (!ready_o || rd_en_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o  <= '0;
            ready_o <= 1'b0;
        end else if (load) begin
            data_o  <= sw_sync;
            ready_o <= 1'b1;
        end else if (rd_en_i) begin
            ready_o <= 1'b0;
        end
    end

`ifdef INPUT_PORT_OVERRUN_EN
    logic drop;

    assign drop = capture && ready_o && !rd_en_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_o <= 1'b0;
        end else if (drop) begin
            overrun_o <= 1'b1;
        end else if (rd_en_i) begin
            overrun_o <= 1'b0;
        end
    end
`else
    assign overrun_o = 1'b0;
`endif

endmodule

// File: tb/tb_input_port.sv
// Directed bench for input_port with a short debounce window (4 cycles).
module tb_input_port;

    localparam int DW = 8;
    localparam int DB = 4;
    localparam int NVEC = 28;

`ifdef INPUT_PORT_OVERRUN_EN
    localparam logic OVR_ON = 1'b1;
`else
    localparam logic OVR_ON = 1'b0;
`endif

    typedef struct {
        logic          btn;
        logic [DW-1:0] sw;
        logic          rd;
        logic          exp_ready;
        logic [DW-1:0] exp_data;
        logic          exp_level;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] sw_i;
    logic          btn_i;
    logic          rd_en_i;
    logic [DW-1:0] data_o;
    logic          ready_o;
    logic          overrun_o;
    logic          btn_level_o;

    int checks = 0;
    int errors = 0;

    vec_t vecs [NVEC];

    input_port #(
        .DATA_WIDTH      (DW),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_i        (sw_i),
        .btn_i       (btn_i),
        .rd_en_i     (rd_en_i),
        .data_o      (data_o),
        .ready_o     (ready_o),
        .overrun_o   (overrun_o),
        .btn_level_o (btn_level_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_stimulus(input logic b, input logic [DW-1:0] s, input logic r);
        btn_i   = b;
        sw_i    = s;
        rd_en_i = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [DW-1:0] s);
        for (int k = 0; k < 2 + DB + 1; k++) apply_stimulus(1'b1, s, 1'b0);
    endtask

    task automatic release_btn(input logic [DW-1:0] s);
        for (int k = 0; k < 8; k++) apply_stimulus(1'b0, s, 1'b0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Clean press of 0xA5 held 20 clocks, two reads, then a full release.
        for (int i = 0; i < NVEC; i++) begin
            vecs[i].btn       = (i < 20);
            vecs[i].sw        = 8'hA5;
            vecs[i].rd        = (i == 10) || (i == 11);
            vecs[i].exp_ready = (i >= 6) && (i <= 9);
            vecs[i].exp_data  = (i >= 6) ? 8'hA5 : 8'h00;
            vecs[i].exp_level = (i >= 6) && (i <= 25);
        end

        rst_n   = 1'b0;
        sw_i    = '0;
        btn_i   = 1'b0;
        rd_en_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_data", 32'(data_o), 32'h0);
        check_output("reset_ready", 32'(ready_o), 32'h0);
        check_output("reset_overrun", 32'(overrun_o), 32'h0);
        check_output("reset_level", 32'(btn_level_o), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(vecs[i].btn, vecs[i].sw, vecs[i].rd);
            check_output($sformatf("vec%0d_ready", i), 32'(ready_o), 32'(vecs[i].exp_ready));
            check_output($sformatf("vec%0d_data", i), 32'(data_o), 32'(vecs[i].exp_data));
            check_output($sformatf("vec%0d_level", i), 32'(btn_level_o), 32'(vecs[i].exp_level));
            check_output($sformatf("vec%0d_overrun", i), 32'(overrun_o), 32'h0);
        end

        // Bounce rejection: two short pulses, then a steady press.
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(((k / 2) % 2) == 0, 8'h5A, 1'b0);
            check_output($sformatf("bounce%0d_ready", k), 32'(ready_o), 32'h0);
        end
        for (int k = 1; k <= 7; k++) begin
            apply_stimulus(1'b1, 8'h5A, 1'b0);
            check_output($sformatf("bounce_rise%0d_ready", k), 32'(ready_o), 32'(k == 7));
        end
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b1, 8'h5A, 1'b0);
            check_output("bounce_hold_ready", 32'(ready_o), 32'h1);
        end
        check_output("bounce_data", 32'(data_o), 32'h5A);
        apply_stimulus(1'b1, 8'h5A, 1'b1);
        check_output("bounce_read_ready", 32'(ready_o), 32'h0);

        // Overrun: 0x11 left unread, then a second press of 0x22.
        release_btn(8'h11);
        press(8'h11);
        check_output("ovr_first_ready", 32'(ready_o), 32'h1);
        check_output("ovr_first_data", 32'(data_o), 32'h11);
        release_btn(8'h22);
        press(8'h22);
        check_output("ovr_second_data", 32'(data_o), 32'h11);
        check_output("ovr_second_ready", 32'(ready_o), 32'h1);
        check_output("ovr_flag", 32'(overrun_o), 32'(OVR_ON));
        apply_stimulus(1'b1, 8'h22, 1'b1);
        check_output("ovr_read_ready", 32'(ready_o), 32'h0);
        check_output("ovr_read_flag", 32'(overrun_o), 32'h0);

        // Read strobe coinciding with the capture cycle of 0x7E while 0x01 is held.
        release_btn(8'h01);
        press(8'h01);
        check_output("sim_hold_data", 32'(data_o), 32'h01);
        release_btn(8'h7E);
        check_output("sim_pre_ready", 32'(ready_o), 32'h1);
        for (int k = 0; k < 6; k++) apply_stimulus(1'b1, 8'h7E, 1'b0);
        apply_stimulus(1'b1, 8'h7E, 1'b1);
        check_output("sim_data", 32'(data_o), 32'h7E);
        check_output("sim_ready", 32'(ready_o), 32'h1);
        check_output("sim_overrun", 32'(overrun_o), 32'h0);
        apply_stimulus(1'b1, 8'h7E, 1'b0);
        check_output("sim_after_ready", 32'(ready_o), 32'h1);

        // Reset while in PRESS_WAIT with a byte pending; button held through release.
        release_btn(8'h33);
        for (int k = 0; k < 3; k++) apply_stimulus(1'b1, 8'h33, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("rst_mid_data", 32'(data_o), 32'h0);
        check_output("rst_mid_ready", 32'(ready_o), 32'h0);
        check_output("rst_mid_overrun", 32'(overrun_o), 32'h0);
        check_output("rst_mid_level", 32'(btn_level_o), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            apply_stimulus(1'b1, 8'h33, 1'b0);
            check_output($sformatf("rst_rel%0d_ready", k), 32'(ready_o), 32'(k == 7));
        end
        check_output("rst_rel_data", 32'(data_o), 32'h33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
